// File: rtl/m31_addsub_arbiter_if.sv
// rtl/m31_addsub_arbiter_if.sv - request/response bus of the shared M31 add/sub arbiter (grant_cnt only with M31_ARB_STATS_EN)
interface m31_addsub_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_op;
    logic [NUM_REQ*31-1:0] req_a;
    logic [NUM_REQ*31-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [30:0]           rsp_data;
`ifdef M31_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_cnt;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, grant_cnt
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, grant_cnt
    );
`else
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
`endif
endinterface

// File: rtl/m31_addsub_arbiter.sv
// rtl/m31_addsub_arbiter.sv - round-robin shared M31 add/sub datapath with one result slot; grant counters with M31_ARB_STATS_EN
module m31_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    m31_addsub_arbiter_if.slave   bus
);
    localparam logic [30:0]     P    = 31'h7FFF_FFFF;
    localparam logic [ID_W:0]   NREQ = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

    typedef enum logic {EMPTY, FULL} slot_state_t;

    slot_state_t     state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rsp_id_q;
    logic [30:0]     rsp_data_q;

    logic            can_accept;
    logic            any_valid;
    logic            grant_ok;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   idx;

    logic [30:0]     op_a;
    logic [30:0]     op_b;
    logic [30:0]     b_eff;
    logic [31:0]     sum;
    logic [30:0]     fold;
    logic [30:0]     result;

    // The slot can take a new result when empty or when it is being drained this cycle
    assign can_accept = (state == EMPTY) | bus.rsp_ready;
    assign grant_ok   = any_valid & can_accept & ~rst;

    // Search upward from rr_ptr with wrap; iterating downward lets the nearest valid win
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req_valid[idx[ID_W-1:0]]) begin
                any_valid = 1'b1;
                grant_idx = idx[ID_W-1:0];
            end
        end
    end

    assign bus.req_ready = grant_ok ? (NUM_REQ'(1) << grant_idx) : '0;

    // Datapath: subtraction adds ~B, which is P-B in 31 bits; one fold suffices since it adds at most 1
    assign op_a   = bus.req_a[31*grant_idx +: 31];
    assign op_b   = bus.req_b[31*grant_idx +: 31];
    assign b_eff  = bus.req_op[grant_idx] ? ~op_b : op_b;
    assign sum    = {1'b0, op_a} + {1'b0, b_eff};
    assign fold   = sum[30:0] + {30'b0, sum[31]};
    assign result = (fold == P) ? 31'b0 : fold;

    // Result-slot FSM: fill on grant, drain on rsp_ready, refill in the same cycle when both happen
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            rr_ptr     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            if (grant_ok) begin
                state      <= FULL;
                rsp_id_q   <= grant_idx;
                rsp_data_q <= result;
                rr_ptr     <= (grant_idx == LAST) ? '0 : grant_idx + ID_W'(1);
            end else if (bus.rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

`ifdef M31_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];

    // Saturating per-requester grant counters, cleared only by reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                grant_cnt_q[i] <= '0;
            end else if (bus.req_ready[i] && grant_cnt_q[i] != 16'hFFFF) begin
                grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        assign bus.grant_cnt[16*gi +: 16] = grant_cnt_q[gi];
    end
`endif
endmodule

// File: tb/tb_m31_addsub_arbiter.sv
// tb/tb_m31_addsub_arbiter.sv - randomized self-checking bench for m31_addsub_arbiter against a modular-arithmetic model
module tb_m31_addsub_arbiter;
    localparam int     N = 4;
    localparam longint P = 64'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    m31_addsub_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();
    m31_addsub_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [3:0]  v;
    logic [3:0]  op;
    logic [30:0] a [N];
    logic [30:0] b [N];
    logic        rdy;

    bit          m_valid;
    int          m_id;
    longint      m_data;
    int          m_ptr;
    logic [3:0]  exp_ready;
    logic [3:0]  obs_ready;

    function automatic longint ref_op(logic o, logic [30:0] x, logic [30:0] y);
        longint xm = longint'(x) % P;
        longint ym = longint'(y) % P;
        return o ? (xm - ym + P) % P : (xm + ym) % P;
    endfunction

    function automatic int pick(logic [3:0] vv, int ptr);
        for (int k = 0; k < N; k++) begin
            if (vv[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [30:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 31'd0;
            1: return 31'd1;
            2: return 31'h7FFF_FFFE;
            3: return 31'h7FFF_FFFF;
            default: return 31'($urandom);
        endcase
    endfunction

    task automatic randomize_req(int i);
        op[i] = 1'($urandom_range(0, 1));
        a[i]  = rand_operand();
        b[i]  = rand_operand();
    endtask

    task automatic apply();
        bus.req_valid = v;
        bus.req_op    = op;
        for (int i = 0; i < N; i++) begin
            bus.req_a[31*i +: 31] = a[i];
            bus.req_b[31*i +: 31] = b[i];
        end
        bus.rsp_ready = rdy;
    endtask

    task automatic tick();
        int g;
        bit acc;
        apply();
        #1;
        obs_ready = bus.req_ready;
        acc       = !m_valid || rdy;
        g         = pick(v, m_ptr);
        exp_ready = (!rst && acc && g >= 0) ? 4'(1 << g) : 4'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_id = 0; m_data = 0; m_ptr = 0;
        end else if (acc && g >= 0) begin
            m_valid = 1;
            m_id    = g;
            m_data  = ref_op(op[g], a[g], b[g]);
            m_ptr   = (g + 1) % N;
        end else if (rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; v = 4'hF; rdy = 1'b1;
        for (int i = 0; i < N; i++) randomize_req(i);
        tick();
        tick();
        checks++; if (obs_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", obs_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 31'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.rsp_data); end
        rst = 1'b0;
        v = 4'b0;
        tick();
    endtask

    task automatic test_add_sub();
        logic [3:0]  sel   [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic        ops   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [30:0] av    [6] = '{31'h7FFFFFFE, 31'h0, 31'h5, 31'h7FFFFFFF, 31'h3, 31'h7FFFFFFF};
        logic [30:0] bv    [6] = '{31'h2, 31'h1, 31'h5, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'h0};
        logic [30:0] want  [6] = '{31'h1, 31'h7FFFFFFE, 31'h0, 31'h0, 31'h3, 31'h0};
        logic [1:0]  wid   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rdy = 1'b1;
        for (int t = 0; t < 6; t++) begin
            v = sel[t];
            op[wid[t]] = ops[t]; a[wid[t]] = av[t]; b[wid[t]] = bv[t];
            tick();
            checks++; if (obs_ready !== sel[t]) begin errors++; $display("FAIL addsub_ready[%0d] got %b want %b", t, obs_ready, sel[t]); end
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL addsub_valid[%0d] got %b want 1", t, bus.rsp_valid); end
            checks++; if (bus.rsp_data !== want[t]) begin errors++; $display("FAIL addsub_data[%0d] got %h want %h", t, bus.rsp_data, want[t]); end
            checks++; if (bus.rsp_id !== wid[t]) begin errors++; $display("FAIL addsub_id[%0d] got %0d want %0d", t, bus.rsp_id, wid[t]); end
        end
        v = 4'b0;
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        v = 4'hF; rdy = 1'b1;
        for (int i = 0; i < N; i++) randomize_req(i);
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (obs_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, obs_ready, 4'(1 << (k % 4))); end
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b want 1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_id[%0d] got %0d want %0d", k, bus.rsp_id, k % 4); end
            checks++; if (bus.rsp_data !== 31'(m_data)) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", k, bus.rsp_data, 31'(m_data)); end
        end
    endtask

    task automatic test_backpressure();
        int     hold_id;
        longint hold_data;
        v = 4'hF; rdy = 1'b1;
        tick();
        hold_id = m_id; hold_data = m_data;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (obs_ready !== 4'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", k, obs_ready); end
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== 2'(hold_id)) begin errors++; $display("FAIL bp_id[%0d] got %0d want %0d", k, bus.rsp_id, hold_id); end
            checks++; if (bus.rsp_data !== 31'(hold_data)) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", k, bus.rsp_data, 31'(hold_data)); end
        end
        rdy = 1'b1;
        tick();
        checks++; if (obs_ready !== 4'(1 << ((hold_id + 1) % 4))) begin errors++; $display("FAIL bp_release_ready got %b want %b", obs_ready, 4'(1 << ((hold_id + 1) % 4))); end
        checks++; if (bus.rsp_id !== 2'((hold_id + 1) % 4)) begin errors++; $display("FAIL bp_release_id got %0d want %0d", bus.rsp_id, (hold_id + 1) % 4); end
        checks++; if (bus.rsp_data !== 31'(m_data)) begin errors++; $display("FAIL bp_release_data got %h want %h", bus.rsp_data, 31'(m_data)); end
    endtask

    task automatic test_reset_mid();
        v = 4'hF; rdy = 1'b1;
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b want 1", bus.rsp_valid); end
        rst = 1'b1;
        tick();
        checks++; if (obs_ready !== 4'b0) begin errors++; $display("FAIL rmid_ready got %b want 0000", obs_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", bus.rsp_valid); end
        rst = 1'b0;
        tick();
        checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ptr_ready got %b want 0001", obs_ready); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rmid_ptr_id got %0d want 0", bus.rsp_id); end
    endtask

    task automatic test_single();
        v = 4'b0100; rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            randomize_req(2);
            tick();
            checks++; if (obs_ready !== 4'b0100) begin errors++; $display("FAIL single_ready[%0d] got %b want 0100", k, obs_ready); end
            checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL single_id[%0d] got %0d want 2", k, bus.rsp_id); end
            checks++; if (bus.rsp_data !== 31'(m_data)) begin errors++; $display("FAIL single_data[%0d] got %h want %h", k, bus.rsp_data, 31'(m_data)); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rdy = 1'($urandom_range(0, 3) != 0);
            tick();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", k, obs_ready, exp_ready); end
            checks++; if (bus.rsp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", k, bus.rsp_valid, m_valid); end
            if (m_valid) begin
                checks++; if (bus.rsp_id !== 2'(m_id)) begin errors++; $display("FAIL rnd_id[%0d] got %0d want %0d", k, bus.rsp_id, m_id); end
                checks++; if (bus.rsp_data !== 31'(m_data)) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", k, bus.rsp_data, 31'(m_data)); end
            end
            for (int i = 0; i < N; i++) begin
                if (!v[i] || exp_ready[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    randomize_req(i);
                end
            end
        end
    endtask

`ifdef M31_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1; tick(); rst = 1'b0;
        v = 4'b1000; rdy = 1'b1;
        for (int k = 0; k < 70000; k++) tick();
        for (int r = 0; r < 2; r++) begin
            checks++; if (bus.grant_cnt[48 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL stats_cnt3[%0d] got %h want ffff", r, bus.grant_cnt[48 +: 16]); end
            checks++; if (bus.grant_cnt[47:0] !== 48'h0) begin errors++; $display("FAIL stats_others[%0d] got %h want 0", r, bus.grant_cnt[47:0]); end
            tick();
            tick();
        end
    endtask
`endif

    initial begin
        rst = 1'b0; v = '0; op = '0; rdy = 1'b0;
        for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; end
        m_valid = 0; m_id = 0; m_data = 0; m_ptr = 0;
        test_reset();
        test_add_sub();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_single();
        test_random();
`ifdef M31_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
